// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between the interconnect (master) and the
// RAM slave front-end (slave).
interface wb_ram_slave_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_w;   // master -> slave write data
    logic [31:0] wb_dat_r;   // slave -> master read data
    logic        wb_ack;
    logic        wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        input  wb_dat_r, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        output wb_dat_r, wb_ack, wb_err
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave front-end for a single-port RAM with a 1-cycle
// registered read. Each accepted request is latched, presented to the RAM
// for exactly one cycle, the read word is captured one cycle later, and an
// ack (or err for undecoded/misaligned addresses) is returned as a pulse.
module wb_ram_slave #(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          EXTRA_WAIT = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_ram_slave_if.slave     wb,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    // Wait counter counts down to zero, so it is loaded one short.
    localparam logic [2:0] WAIT_LOAD = (EXTRA_WAIT > 0) ? 3'(EXTRA_WAIT - 1) : 3'd0;
    localparam bit         HAS_WAIT  = (EXTRA_WAIT > 0);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdat_q, rdat_d;

    logic req;
    logic hit;

    assign req = wb.wb_cyc & wb.wb_stb;
    assign hit = (wb.wb_adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                 (wb.wb_adr[1:0] == 2'b00);

    // Next-state, request latching, read capture and registered bus outputs.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        we_d    = wb.wb_we;
                        adr_d   = wb.wb_adr[ADDR_W+1:2];
                        sel_d   = wb.wb_sel;
                        wdat_d  = wb.wb_dat_w;
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // RAM data for the address presented in ACCESS is valid now.
                rdata_d = ram_dat_i;
                if (HAS_WAIT) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Master abandoning the cycle cancels any pending response.
        if ((state_q != S_IDLE) && !wb.wb_cyc) begin
            state_d = S_IDLE;
        end

        // Outputs are decoded from the next state so they are flops that
        // line up exactly with the ACK/ERR state.
        ack_d  = (state_d == S_ACK);
        err_d  = (state_d == S_ERR);
        rdat_d = ((state_d == S_ACK) && !we_d) ? rdata_d : 32'h0;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= 4'h0;
            wdat_q  <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // The write strobe also watches cyc and reset live so an abort or a
    // reset landing in ACCESS never commits a write.
    assign ram_we_o  = (state_q == S_ACCESS) & we_q & (|sel_q) & wb.wb_cyc & rst_n_i;
    assign ram_adr_o = adr_q;
    assign ram_be_o  = sel_q;
    assign ram_dat_o = wdat_q;

    assign wb.wb_ack   = ack_q;
    assign wb.wb_err   = err_q;
    assign wb.wb_dat_r = rdat_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: two instances (no wait states and
// three wait states), each backed by a small registered-read RAM model.
module tb_wb_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;
    int   last_ack_cyc = 0;
    int   wes0 = 0;
    int   wes3 = 0;

    wb_ram_slave_if bus0();
    wb_ram_slave_if bus3();

    logic        ram_we0, ram_we3;
    logic [11:0] ram_adr0, ram_adr3;
    logic [3:0]  ram_be0, ram_be3;
    logic [31:0] ram_wd0, ram_wd3, ram_rd0, ram_rd3;
    logic [31:0] mem0 [0:4095];
    logic [31:0] mem3 [0:4095];

    wb_ram_slave #(.ADDR_W(12), .BASE_ADDR(32'h0000_0000), .EXTRA_WAIT(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .wb(bus0),
        .ram_we_o(ram_we0), .ram_adr_o(ram_adr0), .ram_be_o(ram_be0),
        .ram_dat_o(ram_wd0), .ram_dat_i(ram_rd0)
    );

    wb_ram_slave #(.ADDR_W(12), .BASE_ADDR(32'h0000_0000), .EXTRA_WAIT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .wb(bus3),
        .ram_we_o(ram_we3), .ram_adr_o(ram_adr3), .ram_be_o(ram_be3),
        .ram_dat_o(ram_wd3), .ram_dat_i(ram_rd3)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // RAM models: byte-enabled write, read-first registered read.
    always @(posedge clk) begin
        if (ram_we0) begin
            wes0 <= wes0 + 1;
            for (int b = 0; b < 4; b++)
                if (ram_be0[b]) mem0[ram_adr0][8*b +: 8] <= ram_wd0[8*b +: 8];
        end
        ram_rd0 <= mem0[ram_adr0];
    end

    always @(posedge clk) begin
        if (ram_we3) begin
            wes3 <= wes3 + 1;
            for (int b = 0; b < 4; b++)
                if (ram_be3[b]) mem3[ram_adr3][8*b +: 8] <= ram_wd3[8*b +: 8];
        end
        ram_rd3 <= mem3[ram_adr3];
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] <= 32'h0;
            mem3[i] <= 32'h0;
        end
        mem0[0]  <= 32'h3401_0000;
        mem0[9]  <= 32'hCAFE_F00D;
        mem0[12] <= 32'h0BAD_0BAD;
        mem0[16] <= 32'h5555_AAAA;
        mem3[0]  <= 32'h1111_2222;
        mem3[1]  <= 32'h3333_4444;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input bit d3, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (d3) begin
            bus3.wb_cyc = cyc; bus3.wb_stb = cyc; bus3.wb_we = we;
            bus3.wb_adr = adr; bus3.wb_sel = sel; bus3.wb_dat_w = dat;
        end else begin
            bus0.wb_cyc = cyc; bus0.wb_stb = cyc; bus0.wb_we = we;
            bus0.wb_adr = adr; bus0.wb_sel = sel; bus0.wb_dat_w = dat;
        end
    endtask

    // One bus transfer starting at the next falling edge (cycle 0).
    // lat = cycle index of the ack/err pulse, -1 if none within 20 cycles.
    // After acceptance the bus inputs are scrambled: the DUT must use its
    // latched copies.
    task automatic xfer(input bit d3, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output int lat, output logic [31:0] rdat, output logic is_err);
        logic ack, err, done;
        @(negedge clk);
        drive(d3, 1'b1, we, adr, sel, dat);
        lat = -1; rdat = 32'h0; is_err = 1'b0; done = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (!done) begin
                @(negedge clk);
                ack = d3 ? bus3.wb_ack : bus0.wb_ack;
                err = d3 ? bus3.wb_err : bus0.wb_err;
                if (ack || err) begin
                    check("ack_err_exclusive", 32'(ack & err), 32'h0);
                    lat = n;
                    is_err = err;
                    rdat = d3 ? bus3.wb_dat_r : bus0.wb_dat_r;
                    last_ack_cyc = cyc_cnt;
                    done = 1'b1;
                end else if (n == 1) begin
                    drive(d3, 1'b1, ~we, 32'hFFFF_FFFC, ~sel, ~dat);
                end
            end
        end
        drive(d3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          w0;
        int          t_first;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ack",     32'(bus0.wb_ack), 32'h0);
        check("rst_err",     32'(bus0.wb_err), 32'h0);
        check("rst_dat",     bus0.wb_dat_r, 32'h0);
        check("rst_ram_we",  32'(ram_we0), 32'h0);
        check("rst_ram_adr", 32'(ram_adr0), 32'h0);
        check("rst_ram_be",  32'(ram_be0), 32'h0);
        check("rst_ram_dat", ram_wd0, 32'h0);
        rst_n = 1'b1;

        // Read word 0 of preloaded RAM
        xfer(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, lat, rd, e);
        check("t1_lat", 32'(lat), 32'd3);
        check("t1_err", 32'(e), 32'h0);
        check("t1_dat", rd, 32'h3401_0000);

        // Partial write then read back
        w0 = wes0;
        xfer(1'b0, 1'b1, 32'h10, 4'b0101, 32'hDEAD_BEEF, lat, rd, e);
        check("t2w_lat",    32'(lat), 32'd3);
        check("t2w_dat0",   rd, 32'h0);
        check("t2w_nwrite", 32'(wes0 - w0), 32'd1);
        check("t2w_mem",    mem0[4], 32'h00AD_00EF);
        xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, lat, rd, e);
        check("t2r_lat", 32'(lat), 32'd3);
        check("t2r_dat", rd, 32'h00AD_00EF);

        // sel=0 write: acked, no RAM write
        w0 = wes0;
        xfer(1'b0, 1'b1, 32'h20, 4'h0, 32'h1234_5678, lat, rd, e);
        check("sel0w_lat",    32'(lat), 32'd3);
        check("sel0w_nwrite", 32'(wes0 - w0), 32'd0);
        check("sel0w_mem",    mem0[8], 32'h0);
        // sel=0 read: full word
        xfer(1'b0, 1'b0, 32'h24, 4'h0, 32'h0, lat, rd, e);
        check("sel0r_lat", 32'(lat), 32'd3);
        check("sel0r_dat", rd, 32'hCAFE_F00D);

        // Out-of-range and misaligned accesses
        w0 = wes0;
        xfer(1'b0, 1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, lat, rd, e);
        check("t3a_lat", 32'(lat), 32'd1);
        check("t3a_err", 32'(e), 32'h1);
        check("t3a_dat", rd, 32'h0);
        xfer(1'b0, 1'b1, 32'h0000_0002, 4'hF, 32'hFFFF_FFFF, lat, rd, e);
        check("t3b_lat", 32'(lat), 32'd1);
        check("t3b_err", 32'(e), 32'h1);
        check("t3_nwrite", 32'(wes0 - w0), 32'd0);
        check("t3_mem0", mem0[0], 32'h3401_0000);

        // Three wait states, back-to-back reads
        xfer(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, lat, rd, e);
        check("t4a_lat", 32'(lat), 32'd6);
        check("t4a_dat", rd, 32'h1111_2222);
        t_first = last_ack_cyc;
        xfer(1'b1, 1'b0, 32'h4, 4'hF, 32'h0, lat, rd, e);
        check("t4b_lat", 32'(lat), 32'd6);
        check("t4b_dat", rd, 32'h3333_4444);
        check("t4_ack_spacing", 32'(last_ack_cyc - t_first), 32'd7);

        // Drop cyc during CAPTURE of a read
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("t5a_no_ack", 32'(bus0.wb_ack | bus0.wb_err), 32'h0);
        @(negedge clk);
        check("t5a_no_ack2", 32'(bus0.wb_ack | bus0.wb_err), 32'h0);
        xfer(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, lat, rd, e);
        check("t5a_next_lat", 32'(lat), 32'd3);
        check("t5a_next_dat", rd, 32'h3401_0000);

        // Drop cyc during ACCESS of a write
        w0 = wes0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t5b_access_we",  32'(ram_we0), 32'h1);
        check("t5b_access_adr", 32'(ram_adr0), 32'd12);
        check("t5b_access_dat", ram_wd0, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check("t5b_we_gated", 32'(ram_we0), 32'h0);
        @(negedge clk);
        check("t5b_no_ack", 32'(bus0.wb_ack | bus0.wb_err), 32'h0);
        check("t5b_nwrite", 32'(wes0 - w0), 32'd0);
        check("t5b_mem",    mem0[12], 32'h0BAD_0BAD);
        xfer(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, lat, rd, e);
        check("t5b_next_lat", 32'(lat), 32'd3);
        check("t5b_next_dat", rd, 32'h0BAD_0BAD);

        // Reset during ACCESS of a write
        w0 = wes0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_we_gated", 32'(ram_we0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("t6_ack",     32'(bus0.wb_ack), 32'h0);
        check("t6_err",     32'(bus0.wb_err), 32'h0);
        check("t6_dat",     bus0.wb_dat_r, 32'h0);
        check("t6_ram_adr", 32'(ram_adr0), 32'h0);
        check("t6_ram_be",  32'(ram_be0), 32'h0);
        check("t6_ram_dat", ram_wd0, 32'h0);
        check("t6_nwrite",  32'(wes0 - w0), 32'd0);
        check("t6_mem",     mem0[16], 32'h5555_AAAA);
        xfer(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, lat, rd, e);
        check("t6_next_lat", 32'(lat), 32'd3);
        check("t6_next_dat", rd, 32'h5555_AAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
